// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the VGA timing generator and the overlay that
// consumes its counters and returns a pixel colour.
interface vga_timing_gen_if;
    logic        pix_en;
    logic [11:0] din;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        video_on;
    logic        frame_start;

    // master: the timing generator; slave: the overlay / board driver side
    modport master (
        input  pix_en, din,
        output h_count, v_count, hs, vs, r, g, b, video_on, frame_start
    );
    modport slave (
        output pix_en, din,
        input  h_count, v_count, hs, vs, r, g, b, video_on, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: free-running counters, registered active-low syncs
// and a registered, blanked 12-bit RGB stage, all advancing on pix_en.
module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] HSyncEnd = 10'(H_SYNC);
    localparam logic [9:0] VSyncEnd = 10'(V_SYNC);
    // Window opens one pixel early to absorb the overlay's registered font fetch.
    localparam logic [9:0] HVisLo   = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] HVisHi   = 10'(H_SYNC + H_BACK - 1 + H_DISP);
    localparam logic [9:0] VVisLo   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VVisHi   = 10'(V_SYNC + V_BACK + V_DISP);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] rgb_q, rgb_d;
    logic        video_on_q, video_on_d;
    logic        frame_start_q, frame_start_d;
    logic        vis;

    assign vis = (h_q >= HVisLo) && (h_q < HVisHi) && (v_q >= VVisLo) && (v_q < VVisHi);

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        rgb_d         = rgb_q;
        video_on_d    = video_on_q;
        frame_start_d = frame_start_q;
        if (vga.pix_en) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            hs_d          = !(h_q < HSyncEnd);
            vs_d          = !(v_q < VSyncEnd);
            video_on_d    = vis;
            rgb_d         = vis ? vga.din : 12'h000;
            frame_start_d = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            rgb_q         <= '0;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.r           = rgb_q[11:8];
    assign vga.g           = rgb_q[7:4];
    assign vga.b           = rgb_q[3:0];
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus a shrunk-timing
// instance so whole frames fit, both checked against a tick-count model.
module tb_vga_timing_gen;

    localparam int SHS = 8;
    localparam int SHB = 6;
    localparam int SHD = 20;
    localparam int SHF = 4;
    localparam int SVS = 2;
    localparam int SVB = 3;
    localparam int SVD = 10;
    localparam int SVF = 2;
    localparam int SHT = SHS + SHB + SHD + SHF;
    localparam int SVT = SVS + SVB + SVD + SVF;

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic [11:0] din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if ifd ();
    vga_timing_gen_if ifs ();

    assign ifd.pix_en = pix_en;
    assign ifd.din    = din;
    assign ifs.pix_en = pix_en;
    assign ifs.din    = din;

    vga_timing_gen dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (ifd.master)
    );

    vga_timing_gen #(
        .H_SYNC (SHS), .H_BACK (SHB), .H_DISP (SHD), .H_FRONT (SHF),
        .V_SYNC (SVS), .V_BACK (SVB), .V_DISP (SVD), .V_FRONT (SVF)
    ) dut_sm (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (ifs.master)
    );

    wire [35:0] got_def = {ifd.h_count, ifd.v_count, ifd.hs, ifd.vs, ifd.r, ifd.g, ifd.b,
                           ifd.video_on, ifd.frame_start};
    wire [35:0] got_sm  = {ifs.h_count, ifs.v_count, ifs.hs, ifs.vs, ifs.r, ifs.g, ifs.b,
                           ifs.video_on, ifs.frame_start};

    int          total = 0;
    int          bad   = 0;
    int          n     = 0;   // pix_en ticks since reset release
    logic [11:0] dl    = '0;  // din presented on the most recent tick
    logic [35:0] exp_def;
    logic [35:0] exp_sm;

    // Outputs after n ticks: counters sit at raster position n, registered
    // outputs describe position n-1.
    function automatic logic [35:0] model(input int nt, input int hsy, input int hbk,
                                          input int hdp, input int hfp, input int vsy,
                                          input int vbk, input int vdp, input int vfp,
                                          input logic [11:0] d);
        int   ht, vt, p, ph, pv;
        logic vis;
        ht = hsy + hbk + hdp + hfp;
        vt = vsy + vbk + vdp + vfp;
        if (nt == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
        p   = nt - 1;
        ph  = p % ht;
        pv  = (p / ht) % vt;
        vis = (ph >= hsy + hbk - 1) && (ph < hsy + hbk - 1 + hdp) &&
              (pv >= vsy + vbk) && (pv < vsy + vbk + vdp);
        return {10'(nt % ht), 10'((nt / ht) % vt), ph >= hsy, pv >= vsy,
                vis ? d : 12'h000, vis, (p % (ht * vt)) == 0};
    endfunction

    task automatic refresh_model();
        exp_def = model(n, 96, 48, 640, 16, 2, 33, 480, 10, dl);
        exp_sm  = model(n, SHS, SHB, SHD, SHF, SVS, SVB, SVD, SVF, dl);
    endtask

    task automatic step(input logic pen, input logic [11:0] d);
        pix_en = pen;
        din    = d;
        @(posedge clk);
        if (pen) begin
            n++;
            dl = d;
        end
        #1;
        refresh_model();
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        pix_en = 1'b1;
        din    = 12'hABC;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        refresh_model();
        total++;
        if (got_def !== exp_def) begin
            bad++;
            $display("FAIL reset_def got=%h exp=%h", got_def, exp_def);
        end
        total++;
        if (got_sm !== exp_sm) begin
            bad++;
            $display("FAIL reset_sm got=%h exp=%h", got_sm, exp_sm);
        end
        rst_n = 1'b1;
        step(1'b1, 12'(($urandom)));
        total++;
        if ({ifd.hs, ifd.vs, ifd.frame_start} !== 3'b001) begin
            bad++;
            $display("FAIL first_tick hs_vs_fs got=%b exp=001", {ifd.hs, ifd.vs, ifd.frame_start});
        end
        total++;
        if (got_def !== exp_def) begin
            bad++;
            $display("FAIL first_tick_def got=%h exp=%h", got_def, exp_def);
        end
    endtask

    task automatic test_sync_counters();
        for (int i = 0; i < 1700; i++) begin
            step(1'b1, 12'($urandom));
            total++;
            if (got_def !== exp_def) begin
                bad++;
                $display("FAIL sync_def n=%0d got=%h exp=%h", n, got_def, exp_def);
            end
            total++;
            if (got_sm !== exp_sm) begin
                bad++;
                $display("FAIL sync_sm n=%0d got=%h exp=%h", n, got_sm, exp_sm);
            end
            if (n == 96 || n == 97) begin
                total++;
                if (ifd.hs !== (n == 97)) begin
                    bad++;
                    $display("FAIL hs_edge n=%0d got=%b exp=%b", n, ifd.hs, n == 97);
                end
            end
            if (n == 800) begin
                total++;
                if ({ifd.h_count, ifd.v_count} !== {10'd0, 10'd1}) begin
                    bad++;
                    $display("FAIL h_wrap got=%0d,%0d exp=0,1", ifd.h_count, ifd.v_count);
                end
            end
        end
    endtask

    task automatic test_frame_small();
        int  len = 0, vs_lo = 0, hs_lo = 0, von = 0;
        bit  started = 0, done = 0;
        for (int i = 0; i < 3 * SHT * SVT && !done; i++) begin
            step(1'b1, 12'($urandom));
            total++;
            if (got_sm !== exp_sm) begin
                bad++;
                $display("FAIL frame_sm n=%0d got=%h exp=%h", n, got_sm, exp_sm);
            end
            if (ifs.frame_start && started) done = 1;
            else begin
                if (ifs.frame_start) started = 1;
                if (started) begin
                    len++;
                    vs_lo += int'(!ifs.vs);
                    hs_lo += int'(!ifs.hs);
                    von   += int'(ifs.video_on);
                end
            end
        end
        total++;
        if (!done || len != SHT * SVT) begin
            bad++;
            $display("FAIL frame_len got=%0d exp=%0d done=%0d", len, SHT * SVT, done);
        end
        total++;
        if (vs_lo != SVS * SHT) begin
            bad++;
            $display("FAIL vs_low got=%0d exp=%0d", vs_lo, SVS * SHT);
        end
        total++;
        if (hs_lo != SHS * SVT) begin
            bad++;
            $display("FAIL hs_low got=%0d exp=%0d", hs_lo, SHS * SVT);
        end
        total++;
        if (von != SHD * SVD) begin
            bad++;
            $display("FAIL video_on_cnt got=%0d exp=%0d", von, SHD * SVD);
        end
    endtask

    task automatic test_video_window();
        logic [11:0] pat   = 12'h100;
        int          first = -1;
        for (int i = 0; i < 32000; i++) begin
            pat = pat + 12'd1;
            step(1'b1, pat);
            total++;
            if (got_def !== exp_def) begin
                bad++;
                $display("FAIL video_def n=%0d got=%h exp=%h", n, got_def, exp_def);
            end
            if (first < 0 && ifd.video_on === 1'b1) first = n;
            if (ifd.h_count == 10'd784 && ifd.v_count == 10'd35) begin
                total++;
                if ({ifd.video_on, ifd.r, ifd.g, ifd.b} !== 13'h0) begin
                    bad++;
                    $display("FAIL blank_783 got=%h exp=0", {ifd.video_on, ifd.r, ifd.g, ifd.b});
                end
            end
            if (first >= 0 && n >= first + 800) break;
        end
        total++;
        if (first != 35 * 800 + 143 + 1) begin
            bad++;
            $display("FAIL first_visible got=%0d exp=%0d", first, 35 * 800 + 144);
        end
    endtask

    task automatic test_pix_en_div4();
        int rise1 = -1, rise2 = -1;
        bit prev  = ifs.frame_start;
        for (int c = 0; c < 4 * SHT * SVT * 3 && rise2 < 0; c++) begin
            step((c % 4) == 0, 12'($urandom));
            total++;
            if (got_def !== exp_def) begin
                bad++;
                $display("FAIL div4_def c=%0d got=%h exp=%h", c, got_def, exp_def);
            end
            total++;
            if (got_sm !== exp_sm) begin
                bad++;
                $display("FAIL div4_sm c=%0d got=%h exp=%h", c, got_sm, exp_sm);
            end
            if (ifs.frame_start && !prev) begin
                if (rise1 < 0) rise1 = c;
                else rise2 = c;
            end
            prev = ifs.frame_start;
        end
        total++;
        if (rise2 < 0 || rise2 - rise1 != 4 * SHT * SVT) begin
            bad++;
            $display("FAIL div4_frame got=%0d exp=%0d", rise2 - rise1, 4 * SHT * SVT);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 800 && (n % 800) != 500; i++) step(1'b1, 12'($urandom));
        #2 rst_n = 1'b0;
        #1;
        n = 0;
        refresh_model();
        total++;
        if (got_def !== exp_def) begin
            bad++;
            $display("FAIL async_rst_def got=%h exp=%h", got_def, exp_def);
        end
        total++;
        if (got_sm !== exp_sm) begin
            bad++;
            $display("FAIL async_rst_sm got=%h exp=%h", got_sm, exp_sm);
        end
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 12'($urandom));
        total++;
        if (ifs.frame_start !== 1'b1 || got_def !== exp_def) begin
            bad++;
            $display("FAIL restart got=%h fs=%b exp=%h", got_def, ifs.frame_start, exp_def);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom));
            total++;
            if (got_def !== exp_def) begin
                bad++;
                $display("FAIL b2b_def n=%0d got=%h exp=%h", n, got_def, exp_def);
            end
            total++;
            if (got_sm !== exp_sm) begin
                bad++;
                $display("FAIL b2b_sm n=%0d got=%h exp=%h", n, got_sm, exp_sm);
            end
        end
    endtask

    initial begin
        pix_en = 1'b0;
        din    = '0;
        test_reset();
        test_sync_counters();
        test_frame_small();
        test_video_window();
        test_pix_en_div4();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing: free-running h_count/v_count, hs/vs sync, and a registered 12-bit RGB output stage.
- Feeds h_count/v_count to the on-screen debug overlay and accepts that overlay's 12-bit pixel colour back on din.
- Sits between the pixel-rate clock domain and the board VGA connector; one instance per display.

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch
H_DISP, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_DISP, 480, visible lines per frame
V_FRONT, 10, vertical front porch

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel strobe; all state advances only when 1 (tie 1 for a 25 MHz clk)
din  input  12  pixel colour from overlay, {R[11:8],G[7:4],B[3:0]}
h_count  output  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
v_count  output  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
hs  output  1  hsync, active low, registered
vs  output  1  vsync, active low, registered
r  output  4  red, registered
g  output  4  green, registered
b  output  4  blue, registered
video_on  output  1  registered, 1 while r/g/b carry visible pixels
frame_start  output  1  one-pix_en-tick pulse at start of each frame

Behaviour:
- Async reset (rst_n=0): h_count=0, v_count=0, hs=1, vs=1, r=g=b=0, video_on=0, frame_start=0. Reset mid-line or mid-frame aborts immediately; after release, counting restarts from (0,0) at the first pix_en.
- pix_en=0: every register holds its value, outputs included.
- Counters, on pix_en=1:
  - h_count increments; at H_TOTAL-1 (799) it wraps to 0 and v_count advances.
  - v_count wraps from V_TOTAL-1 (524) to 0, only coincident with the h wrap.
  - Both are plain registers, no combinational path from din.
- Sync, registered from the current counters on the pix_en tick:
  - hs <= !(h_count < H_SYNC), so low for h_count 0..95.
  - vs <= !(v_count < V_SYNC), so low for v_count 0..1.
  - Sync is therefore one tick behind the counters, matching the RGB stage.
- Visible window, combinational on the current counters:
  - vis = (h_count >= H_SYNC+H_BACK-1) && (h_count < H_SYNC+H_BACK-1+H_DISP) && (v_count >= V_SYNC+V_BACK) && (v_count < V_SYNC+V_BACK+V_DISP).
  - With defaults: h_count 143..782 and v_count 35..514.
  - The one-pixel horizontal lead compensates the overlay's registered character/font pipeline.
- RGB stage, on the pix_en tick:
  - video_on <= vis.
  - {r,g,b} <= vis ? din : 12'h000.
  - Blanked intervals are always driven to 0 regardless of din.
- frame_start: registered; 1 for exactly one pix_en tick when the counters were (0,0), otherwise 0.
- Widths: H_TOTAL and V_TOTAL are localparams (sums of the parameters). Comparisons are 10-bit unsigned; totals must be ≤1024 (not checked in RTL).

Test Plan:
- Reset then pix_en=1 continuous → cycle 1 after release: hs=0, vs=0, frame_start=1. hs rises to 1 on the tick after h_count=95. h_count 799→0 increments v_count 0→1.
- Run one full frame → exactly 525×800=420000 pix_en ticks between frame_start pulses. vs low for exactly 1600 ticks. hs low for 96 ticks per line, 525 lines.
- din=12'hF00 held, count video_on ticks per frame → 307200. r=4'hF only when video_on=1, r=g=b=0 elsewhere. First visible output follows counters (143,35).
- pix_en toggling 1,0,0,0 (÷4 strobe) → all outputs and counters change only after pix_en=1 cycles. Frame length is 4×420000 clk cycles.
- Assert rst_n=0 asynchronously at (h=500,v=200) between clk edges → outputs go to reset values without a clk edge. On release, restart at (0,0) with frame_start=1 on the first tick.
- din changes every tick (incrementing pattern) inside the window → {r,g,b} equals din sampled on the previous pix_en tick (1-tick latency), and 0 at h_count=783.
